// File: rtl/tinker_mem_pkg.sv
// Shared types and default sizes for the byte-serial memory port arbiter.
package tinker_mem_pkg;

    typedef enum logic [1:0] {IDLE, XFER, LAST, RESP} state_t;
    typedef enum logic {PORT_FETCH, PORT_DATA} port_t;

    localparam int DEFAULT_MEM_ADDR_W  = 19;
    localparam int DEFAULT_FETCH_BYTES = 4;
    localparam int DEFAULT_DATA_BYTES  = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; on a tie the port not granted last time wins.
module rr_arbiter2
    import tinker_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_fetch,
    input  logic req_data,
    output logic gnt_fetch,
    output logic gnt_data
);

    port_t last_grant;

    always_comb begin
        gnt_fetch = 1'b0;
        gnt_data  = 1'b0;
        if (en) begin
            if (req_fetch && (!req_data || last_grant == PORT_DATA)) begin
                gnt_fetch = 1'b1;
            end else if (req_data) begin
                gnt_data = 1'b1;
            end
        end
    end

    // A grant is the handshake itself, so history advances on every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_DATA;
        end else if (gnt_fetch) begin
            last_grant <= PORT_FETCH;
        end else if (gnt_data) begin
            last_grant <= PORT_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between instruction fetch and data load/store,
// serialising each word into little-endian byte cycles.
module mem_port_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int MEM_ADDR_W  = DEFAULT_MEM_ADDR_W,
    parameter int FETCH_BYTES = DEFAULT_FETCH_BYTES,
    parameter int DATA_BYTES  = DEFAULT_DATA_BYTES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_req_valid,
    output logic                     f_req_ready,
    input  logic [63:0]              f_addr,
    output logic                     f_resp_valid,
    output logic [8*FETCH_BYTES-1:0] f_resp_data,
    input  logic                     d_req_valid,
    output logic                     d_req_ready,
    input  logic                     d_we,
    input  logic [63:0]              d_addr,
    input  logic [8*DATA_BYTES-1:0]  d_wdata,
    output logic                     d_resp_valid,
    output logic [8*DATA_BYTES-1:0]  d_resp_data,
    output logic [MEM_ADDR_W-1:0]    mem_addr,
    output logic                     mem_we,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata,
    output logic                     busy
);

    localparam int K_W     = $clog2(DATA_BYTES);
    localparam int FETCH_W = 8 * FETCH_BYTES;
    localparam int DATA_W  = 8 * DATA_BYTES;
    localparam logic [K_W-1:0] FETCH_LAST_K = K_W'(FETCH_BYTES - 1);
    localparam logic [K_W-1:0] DATA_LAST_K  = K_W'(DATA_BYTES - 1);

    state_t                  state_q;
    state_t                  state_d;
    port_t                   port_q;
    logic                    we_q;
    logic [MEM_ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       result_q;
    logic [K_W-1:0]          k_q;
    logic                    gnt_fetch;
    logic                    gnt_data;
    logic                    last_byte;
    logic                    unused_bits;

    // Ready is suppressed during reset so no handshake is lost to it.
    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (state_q == IDLE && !reset),
        .req_fetch (f_req_valid),
        .req_data  (d_req_valid),
        .gnt_fetch (gnt_fetch),
        .gnt_data  (gnt_data)
    );

    assign last_byte   = (k_q == ((port_q == PORT_FETCH) ? FETCH_LAST_K : DATA_LAST_K));
    assign unused_bits = ^{f_addr[63:MEM_ADDR_W], d_addr[63:MEM_ADDR_W], result_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (gnt_fetch || gnt_data) state_d = XFER;
            XFER: if (last_byte) state_d = we_q ? RESP : LAST;
            LAST: state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        f_req_ready  = gnt_fetch;
        d_req_ready  = gnt_data;
        busy         = (state_q != IDLE);
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = 8'h00;
        f_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        case (state_q)
            XFER: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = we_q ? wdata_q[7:0] : 8'h00;
            end
            RESP: begin
                f_resp_valid = (port_q == PORT_FETCH);
                d_resp_valid = (port_q == PORT_DATA);
            end
            default: ;
        endcase
    end

    // Request latch and byte walker: address and store data advance one
    // byte per XFER cycle, read bytes shift in from the top.
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (gnt_fetch || gnt_data) begin
                    port_q  <= gnt_fetch ? PORT_FETCH : PORT_DATA;
                    we_q    <= gnt_data && d_we;
                    addr_q  <= gnt_fetch ? f_addr[MEM_ADDR_W-1:0] : d_addr[MEM_ADDR_W-1:0];
                    wdata_q <= d_wdata;
                    k_q     <= '0;
                end
            end
            XFER: begin
                addr_q  <= addr_q + 1'b1;
                k_q     <= k_q + 1'b1;
                wdata_q <= wdata_q >> 8;
                if (k_q != '0) begin
                    result_q <= {mem_rdata, result_q[DATA_W-1:8]};
                end
            end
            default: ;
        endcase
    end

    // The final byte arrives in LAST and goes straight into the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_resp_data <= '0;
            d_resp_data <= '0;
        end else if (state_q == LAST) begin
            if (port_q == PORT_FETCH) begin
                f_resp_data <= {mem_rdata, result_q[DATA_W-1 -: FETCH_W-8]};
            end else begin
                d_resp_data <= {mem_rdata, result_q[DATA_W-1:8]};
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// and a byte-array memory behind the port.
module tb_mem_port_arbiter;

    localparam int AW  = 19;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req_valid, f_req_ready, f_resp_valid;
    logic [63:0]   f_addr;
    logic [31:0]   f_resp_data;
    logic          d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [63:0]   d_addr, d_wdata, d_resp_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          busy;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;
    logic [7:0]    mem     [0:MSZ-1];
    logic [7:0]    ref_mem [0:MSZ-1];
    logic [AW-1:0] addr_seq [8];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: a transfer is an offset t counted from the handshake.
    // Bytes are on the bus for t = 1..n; a store answers at n+1, a load at n+2.
    bit          m_busy = 1'b0;
    bit          m_port;
    bit          m_we;
    bit          m_last = 1'b1;
    int          m_t, m_n, m_rt;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_fdata = '0;
    logic [63:0] m_ddata = '0;

    always @(posedge clk) begin
        logic [63:0] v;
        if (pl_en) ref_mem[pl_addr] = pl_data;
        if (m_busy && m_we && m_t <= m_n) ref_mem[AW'(m_addr + 64'(m_t - 1))] = m_wdata[8*(m_t-1) +: 8];
        if (reset) begin
            m_busy = 1'b0; m_last = 1'b1; m_fdata = '0; m_ddata = '0;
        end else if (!m_busy) begin
            if (f_req_valid || d_req_valid) begin
                m_port = !(f_req_valid && (!d_req_valid || m_last));
                m_we    = m_port && d_we;
                m_addr  = m_port ? d_addr : f_addr;
                m_wdata = d_wdata;
                m_n     = m_port ? 8 : 4;
                m_rt    = m_we ? m_n + 1 : m_n + 2;
                m_last  = m_port;
                m_busy  = 1'b1;
                m_t     = 1;
            end
        end else if (m_t == m_rt) begin
            m_busy = 1'b0;
        end else begin
            m_t++;
            if (m_t == m_rt && !m_we) begin
                v = '0;
                for (int i = 0; i < m_n; i++) v[8*i +: 8] = ref_mem[AW'(m_addr + 64'(i))];
                if (m_port) m_ddata = v; else m_fdata = v[31:0];
            end
        end
    end

    always @(negedge clk) begin
        logic e_fr, e_dr, e_busy, e_we, e_fv, e_dv, cmp_bus;
        logic [AW-1:0] e_addr;
        logic [7:0] e_wd;
        if (chk_en) begin
            e_fr = 0; e_dr = 0; e_busy = 0; e_we = 0; e_fv = 0; e_dv = 0;
            e_addr = '0; e_wd = 8'h00; cmp_bus = 1;
            if (!m_busy) begin
                e_fr = !reset && f_req_valid && (!d_req_valid || m_last);
                e_dr = !reset && d_req_valid && !e_fr;
            end else begin
                e_busy  = 1;
                cmp_bus = (m_t <= m_n);
                e_we    = m_we && m_t <= m_n;
                e_addr  = AW'(m_addr + 64'(m_t - 1));
                e_wd    = e_we ? m_wdata[8*(m_t-1) +: 8] : 8'h00;
                e_fv    = (m_t == m_rt) && !m_port;
                e_dv    = (m_t == m_rt) && m_port;
            end
            chk("f_req_ready", 64'(f_req_ready), 64'(e_fr));
            chk("d_req_ready", 64'(d_req_ready), 64'(e_dr));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("f_resp_valid", 64'(f_resp_valid), 64'(e_fv));
            chk("d_resp_valid", 64'(d_resp_valid), 64'(e_dv));
            chk("f_resp_data", 64'(f_resp_data), 64'(m_fdata));
            chk("d_resp_data", d_resp_data, m_ddata);
            if (cmp_bus) begin
                chk("mem_addr", 64'(mem_addr), 64'(e_addr));
                chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic handshake(input bit p, input bit we, input logic [63:0] a, input logic [63:0] wd);
        bit hs = 1'b0;
        if (p) begin d_req_valid = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else begin f_req_valid = 1; f_addr = a; end
        for (int i = 0; i < 50 && !hs; i++) begin
            #1; hs = p ? d_req_ready : f_req_ready;
            tick();
        end
        f_req_valid = 0; d_req_valid = 0; d_we = 0;
        chk("handshake", 64'(hs), 64'd1);
    endtask

    task automatic wait_resp(input bit p, output int lat, output logic [63:0] rd);
        lat = -1; rd = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            #1;
            if (c <= 8) addr_seq[c-1] = mem_addr;
            if (p ? d_resp_valid : f_resp_valid) begin
                lat = c;
                rd  = p ? d_resp_data : {32'h0, f_resp_data};
            end
            tick();
        end
        chk("resp_seen", 64'(lat > 0), 64'd1);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 0;
    endtask

    initial begin
        int lat, g, dv, fr;
        logic [63:0] rd;
        bit grants [4];
        logic [AW-1:0] wrap_exp [8];

        reset = 1; pl_en = 0; pl_addr = '0; pl_data = '0;
        f_req_valid = 0; f_addr = '0; d_req_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        tick();
        chk_en = 1;
        preload(19'h00000, 8'h11); preload(19'h00001, 8'h22);
        preload(19'h00002, 8'h33); preload(19'h00003, 8'h44);
        preload(19'h7FFFC, 8'hA1); preload(19'h7FFFD, 8'hA2);
        preload(19'h7FFFE, 8'hA3); preload(19'h7FFFF, 8'hA4);
        reset = 0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fdata", 64'(f_resp_data), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        tick();

        // fetch from 0x0
        handshake(0, 0, 64'h0, 64'h0);
        wait_resp(0, lat, rd);
        chk("fetch_lat", 64'(lat), 64'd6);
        chk("fetch_data", rd, 64'h44332211);

        // store then load at 0x100
        handshake(1, 1, 64'h100, 64'h0807060504030201);
        wait_resp(1, lat, rd);
        chk("store_lat", 64'(lat), 64'd9);
        chk("mem_100", 64'(mem[19'h100]), 64'h01);
        chk("mem_107", 64'(mem[19'h107]), 64'h08);
        handshake(1, 0, 64'h100, 64'h0);
        wait_resp(1, lat, rd);
        chk("load_lat", 64'(lat), 64'd10);
        chk("load_data", rd, 64'h0807060504030201);

        // continuous contention after reset
        reset = 1; tick(); reset = 0;
        f_req_valid = 1; f_addr = 64'h0; d_req_valid = 1; d_we = 0; d_addr = 64'h100;
        g = 0;
        for (int i = 0; i < 200 && g < 4; i++) begin
            #1;
            chk("ready_while_busy", 64'((f_req_ready | d_req_ready) & busy), 64'd0);
            if (f_req_ready) begin grants[g] = 0; g++; end
            else if (d_req_ready) begin grants[g] = 1; g++; end
            tick();
        end
        f_req_valid = 0; d_req_valid = 0;
        chk("grant_count", 64'(g), 64'd4);
        chk("grant0", 64'(grants[0]), 64'd0);
        chk("grant1", 64'(grants[1]), 64'd1);
        chk("grant2", 64'(grants[2]), 64'd0);
        chk("grant3", 64'(grants[3]), 64'd1);
        for (int i = 0; i < 30 && busy; i++) tick();
        chk("drain_idle", 64'(busy), 64'd0);
        tick();

        // load across the top of memory
        handshake(1, 0, 64'h7FFFC, 64'h0);
        wait_resp(1, lat, rd);
        wrap_exp = '{19'h7FFFC, 19'h7FFFD, 19'h7FFFE, 19'h7FFFF, 19'h0, 19'h1, 19'h2, 19'h3};
        for (int i = 0; i < 8; i++) chk($sformatf("wrap_addr%0d", i), 64'(addr_seq[i]), 64'(wrap_exp[i]));
        chk("wrap_data", rd, 64'h44332211A4A3A2A1);

        // reset during the third store byte
        handshake(1, 1, 64'h200, 64'hF8F7F6F5F4F3F2F1);
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_mem_addr", 64'(mem_addr), 64'd0);
        chk("abort_dvalid", 64'(d_resp_valid), 64'd0);
        chk("abort_ddata", d_resp_data, 64'd0);
        tick();
        chk("abort_mem_202", 64'(mem[19'h202]), 64'hF3);
        chk("abort_mem_203", 64'(mem[19'h203]), 64'h00);
        handshake(1, 0, 64'h200, 64'h0);
        wait_resp(1, lat, rd);
        chk("after_abort_lat", 64'(lat), 64'd10);
        chk("after_abort_data", rd, 64'h0000000000F3F2F1);

        // fetch waits behind an active data store
        handshake(1, 1, 64'h300, 64'h1122334455667788);
        f_req_valid = 1; f_addr = 64'h0;
        dv = -1; fr = -1;
        for (int c = 1; c <= 30 && fr < 0; c++) begin
            #1;
            if (d_resp_valid && dv < 0) dv = c;
            if (f_req_ready) fr = c;
            tick();
        end
        f_req_valid = 0;
        chk("blocked_store_resp", 64'(dv), 64'd9);
        chk("blocked_fetch_grant", 64'(fr), 64'd10);
        wait_resp(0, lat, rd);
        chk("blocked_fetch_lat", 64'(lat), 64'd6);
        chk("blocked_fetch_data", rd, 64'h44332211);

        tick(); tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
